// File: rtl/cosmic_sound_latch.sv
// Two 8-bit addressable sound latches (one 16-bit register) that turn CPU bit
// writes into fixed-width trigger and stop pulses for a samples player.
module cosmic_sound_latch #(
    parameter int          PULSE_LEN = 16,
    parameter logic [15:0] LOOP_MASK = 16'h0000,
    parameter int          EN_BIT    = 15
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CPU_WR,
    input  logic [3:0]  CPU_ADDR,
    input  logic        CPU_DATA0,
    output logic [15:0] O_SoundPort,
    output logic [15:0] O_SoundStop,
    output logic        O_Sound_EN,
    output logic [15:0] O_LATCH
);

    localparam logic [7:0] LOAD   = 8'(PULSE_LEN);
    localparam logic [3:0] EN_IDX = 4'(EN_BIT);

    logic [15:0] latch_q, latch_nxt;
    logic [7:0]  trig_cnt [16];
    logic [7:0]  stop_cnt [16];
    logic [7:0]  trig_nxt [16];
    logic [7:0]  stop_nxt [16];
    logic [15:0] port_q, stop_q;
    logic [15:0] sel, rise, fall;
    logic        old_bit, en_now, en_clear;

    // CPU_WR is a one-cycle strobe with no backpressure: every strobe is
    // accepted at the edge it is sampled on, and rise/fall are judged against
    // the latch contents (and enable) as they were before that edge.
    always_comb begin
        sel       = {15'b0, CPU_WR} << CPU_ADDR;
        old_bit   = latch_q[CPU_ADDR];
        en_now    = latch_q[EN_IDX];
        en_clear  = sel[EN_IDX] & old_bit & ~CPU_DATA0;
        latch_nxt = latch_q;
        if (CPU_WR)
            latch_nxt[CPU_ADDR] = CPU_DATA0;
        for (int i = 0; i < 16; i++) begin
            rise[i] = sel[i] & ~old_bit & CPU_DATA0 & en_now & (i != EN_BIT);
            fall[i] = sel[i] & old_bit & ~CPU_DATA0 & LOOP_MASK[i] & (i != EN_BIT);

            // Reload beats the decrement, so a retrigger never leaves a gap.
            if (fall[i] | en_clear)
                trig_nxt[i] = 8'd0;
            else if (rise[i])
                trig_nxt[i] = LOAD;
            else if (trig_cnt[i] != 8'd0)
                trig_nxt[i] = trig_cnt[i] - 8'd1;
            else
                trig_nxt[i] = 8'd0;

            if (fall[i] | (en_clear & LOOP_MASK[i] & latch_q[i] & (i != EN_BIT)))
                stop_nxt[i] = LOAD;
            else if (stop_cnt[i] != 8'd0)
                stop_nxt[i] = stop_cnt[i] - 8'd1;
            else
                stop_nxt[i] = 8'd0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            latch_q <= 16'h0000;
            port_q  <= 16'h0000;
            stop_q  <= 16'h0000;
            for (int i = 0; i < 16; i++) begin
                trig_cnt[i] <= 8'd0;
                stop_cnt[i] <= 8'd0;
            end
        end else begin
            latch_q <= latch_nxt;
            for (int i = 0; i < 16; i++) begin
                trig_cnt[i] <= trig_nxt[i];
                stop_cnt[i] <= stop_nxt[i];
                port_q[i]   <= (trig_nxt[i] != 8'd0);
                stop_q[i]   <= (stop_nxt[i] != 8'd0);
            end
        end
    end

    assign O_SoundPort = port_q;
    assign O_SoundStop = stop_q;
    assign O_Sound_EN  = latch_q[EN_IDX];
    assign O_LATCH     = latch_q;

endmodule

// File: tb/tb_cosmic_sound_latch.sv
// Scoreboard bench: two parameterisations driven in lockstep, each checked
// every cycle against a timestamp-based model of the latch and its pulses.
module tb_cosmic_sound_latch;

    logic        clk;
    logic        reset;
    logic        cpu_wr;
    logic [3:0]  cpu_addr;
    logic        cpu_data0;
    logic [15:0] port_a, stop_a, latch_a, port_b, stop_b, latch_b;
    logic        en_a, en_b;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [48:0] exp_q_a[$];
    logic [48:0] exp_q_b[$];

    // Model state: latch image plus the last edge index each pulse is high.
    logic [15:0] m_latch [2];
    int          trig_until [2][16];
    int          stop_until [2][16];

    localparam int          PL_B   = 4;
    localparam logic [15:0] MASK_B = 16'h0006;

    cosmic_sound_latch dut_a (
        .CLK(clk), .RESET(reset), .CPU_WR(cpu_wr), .CPU_ADDR(cpu_addr),
        .CPU_DATA0(cpu_data0), .O_SoundPort(port_a), .O_SoundStop(stop_a),
        .O_Sound_EN(en_a), .O_LATCH(latch_a)
    );

    cosmic_sound_latch #(.PULSE_LEN(PL_B), .LOOP_MASK(MASK_B), .EN_BIT(15)) dut_b (
        .CLK(clk), .RESET(reset), .CPU_WR(cpu_wr), .CPU_ADDR(cpu_addr),
        .CPU_DATA0(cpu_data0), .O_SoundPort(port_b), .O_SoundStop(stop_b),
        .O_Sound_EN(en_b), .O_LATCH(latch_b)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        reset     = 1'b1;
        cpu_wr    = 1'b0;
        cpu_addr  = 4'd0;
        cpu_data0 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_latch[k] = 16'h0;
            for (int i = 0; i < 16; i++) begin
                trig_until[k][i] = -1;
                stop_until[k][i] = -1;
            end
        end
    end

    task automatic model_step(input int k, input int pl, input logic [15:0] mask,
                              input logic rst, input logic wr, input logic [3:0] addr,
                              input logic data, output logic [48:0] exp_v);
        logic [15:0] port, stop;
        logic        old;
        if (rst) begin
            m_latch[k] = 16'h0;
            for (int i = 0; i < 16; i++) begin
                trig_until[k][i] = -1;
                stop_until[k][i] = -1;
            end
        end else if (wr) begin
            old = m_latch[k][addr];
            if (addr != 4'd15) begin
                if (!old && data && m_latch[k][15])
                    trig_until[k][addr] = cyc + pl - 1;
                if (old && !data && mask[addr]) begin
                    stop_until[k][addr] = cyc + pl - 1;
                    trig_until[k][addr] = -1;
                end
            end else if (old && !data) begin
                for (int i = 0; i < 15; i++) begin
                    trig_until[k][i] = -1;
                    if (mask[i] && m_latch[k][i])
                        stop_until[k][i] = cyc + pl - 1;
                end
            end
            m_latch[k][addr] = data;
        end
        for (int i = 0; i < 16; i++) begin
            port[i] = (i != 15) && (cyc <= trig_until[k][i]);
            stop[i] = (i != 15) && (cyc <= stop_until[k][i]);
        end
        exp_v = {m_latch[k], m_latch[k][15], stop, port};
    endtask

    // driver: one call per clock edge, pushes that edge's expected outputs
    task automatic do_cycle(input logic rst, input logic wr, input logic [3:0] addr,
                            input logic data);
        logic [48:0] ea, eb;
        @(negedge clk);
        reset     = rst;
        cpu_wr    = wr;
        cpu_addr  = addr;
        cpu_data0 = data;
        cyc++;
        model_step(0, 16, 16'h0000, rst, wr, addr, data, ea);
        model_step(1, PL_B, MASK_B, rst, wr, addr, data, eb);
        exp_q_a.push_back(ea);
        exp_q_b.push_back(eb);
    endtask

    task automatic wr_bit(input logic [3:0] addr, input logic data);
        do_cycle(1'b0, 1'b1, addr, data);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++)
            do_cycle(1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic check(input string name, input logic [48:0] got, input logic [48:0] exp_v);
        tests++;
        if (got !== exp_v) begin
            fails++;
            $display("FAIL %s cyc=%0d got latch=%h en=%b stop=%h port=%h want latch=%h en=%b stop=%h port=%h",
                     name, cyc, got[48:33], got[32], got[31:16], got[15:0],
                     exp_v[48:33], exp_v[32], exp_v[31:16], exp_v[15:0]);
        end
    endtask

    // monitor: outputs are valid every cycle, sampled just after the edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q_a.size() != 0)
                check("dut_a", {latch_a, en_a, stop_a, port_a}, exp_q_a.pop_front());
            if (exp_q_b.size() != 0)
                check("dut_b", {latch_b, en_b, stop_b, port_b}, exp_q_b.pop_front());
        end
    end

    initial begin
        int r;
        do_cycle(1'b1, 1'b0, 4'd0, 1'b0);
        do_cycle(1'b1, 1'b1, 4'd15, 1'b1);
        idle(2);

        // enable, trigger, then retrigger ten cycles into the pulse
        wr_bit(4'd15, 1'b1);
        wr_bit(4'd3, 1'b1);
        idle(9);
        wr_bit(4'd3, 1'b0);
        wr_bit(4'd3, 1'b1);
        idle(20);
        wr_bit(4'd3, 1'b1);
        wr_bit(4'd3, 1'b0);
        wr_bit(4'd3, 1'b0);
        idle(3);

        // looped channel: set then clear
        wr_bit(4'd1, 1'b1);
        idle(1);
        wr_bit(4'd1, 1'b0);
        idle(6);

        // master disable with looped channels latched, then a suppressed rise
        wr_bit(4'd1, 1'b1);
        wr_bit(4'd2, 1'b1);
        wr_bit(4'd15, 1'b0);
        idle(5);
        wr_bit(4'd4, 1'b1);
        idle(3);
        wr_bit(4'd15, 1'b1);
        idle(3);

        // reset with a write pending during an active pulse
        wr_bit(4'd5, 1'b1);
        idle(2);
        do_cycle(1'b1, 1'b1, 4'd15, 1'b0);
        idle(20);

        // random traffic, enable written often enough to toggle
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 399));
            if (r == 0)
                do_cycle(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            else if (r < 200)
                idle(1);
            else if (r < 240)
                wr_bit(4'd15, 1'($urandom_range(0, 3) != 0));
            else
                wr_bit(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        idle(2);

        for (int w = 0; w < 10 && (exp_q_a.size() != 0 || exp_q_b.size() != 0); w++)
            @(negedge clk);
        tests++;
        if (exp_q_a.size() != 0 || exp_q_b.size() != 0) begin
            fails++;
            $display("FAIL drain left=%0d/%0d want 0/0", exp_q_a.size(), exp_q_b.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cosmic_sound_latch.md
COSMIC_SOUND_LATCH -- requirements
Module: cosmic_sound_latch

Interface
REQ-001 SHALL have parameter PULSE_LEN, default 16: trigger and stop pulse width in CLK cycles; legal range 1..255.
REQ-002 SHALL have parameter LOOP_MASK, default 16'h0000: channels whose latch falling edge issues a stop pulse.
REQ-003 SHALL have parameter EN_BIT, default 15: latch bit acting as master sound enable; that channel never pulses.
REQ-004 CLK  in  1  system clock (clk_sys); the only clock.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 CPU_WR  in  1  single-cycle write strobe from the CPU sound-port decode.
REQ-007 CPU_ADDR  in  4  latch bit select; bit 3 chooses latch A (0) or latch B (1).
REQ-008 CPU_DATA0  in  1  value written to the selected bit.
REQ-009 O_SoundPort  out  16  per-channel trigger pulses to the samples player.
REQ-010 O_SoundStop  out  16  per-channel stop pulses to the samples player.
REQ-011 O_Sound_EN  out  1  current value of latch bit EN_BIT.
REQ-012 O_LATCH  out  16  current contents of both latches, for debug.

Function
REQ-013 SHALL model two 8-bit addressable latches as one 16-bit register latch_q, indexed by CPU_ADDR.
REQ-014 On a CLK edge with CPU_WR=1, SHALL set latch_q[CPU_ADDR] to CPU_DATA0 and leave all other bits unchanged.
REQ-015 Rise condition: for channel i != EN_BIT, a write that takes bit i from 0 to 1 while O_Sound_EN=1 (enable value before the write).
REQ-016 On a rise, SHALL load channel i's pulse counter with PULSE_LEN at the same edge that updates the latch.
REQ-017 O_SoundPort[i] SHALL be registered and high exactly while trig counter i != 0; each clock decrements a nonzero counter.
REQ-018 Result of REQ-016/017: the pulse is high after edge k (the write edge) and low after edge k+PULSE_LEN.
REQ-019 A rise while O_SoundPort[i] is high SHALL reload the counter to PULSE_LEN, so the output stays high with no gap.
REQ-020 A reload coinciding with the count reaching zero SHALL take priority; no low cycle.
REQ-021 A write of 1 to a bit already 1, or 0 to a bit already 0, SHALL produce no pulse on either output.
REQ-022 Fall condition: for channel i in LOOP_MASK, a write taking bit i from 1 to 0 SHALL load stop counter i with PULSE_LEN.
REQ-023 A fall SHALL clear trig counter i in the same cycle.
REQ-024 O_SoundStop[i] SHALL follow the same rules as REQ-017 to REQ-020, using the stop counter.
REQ-025 Clearing the EN_BIT latch bit SHALL:
  - clear all trig counters;
  - load the stop counter of every LOOP_MASK channel whose latch bit is 1.
REQ-026 While O_Sound_EN=0, SHALL suppress all rises; latch bits SHALL still update.
REQ-027 Setting EN_BIT SHALL NOT retroactively trigger channels already latched at 1.
REQ-028 O_SoundPort[EN_BIT] and O_SoundStop[EN_BIT] SHALL be constantly 0.
REQ-029 Counter width SHALL be 8 bits; there SHALL be no wrap-around below zero.

Reset
REQ-030 With RESET=1 at a CLK edge, SHALL clear latch_q, all counters, O_SoundPort, O_SoundStop and O_Sound_EN to 0.
REQ-031 All outputs SHALL read 0 from that edge onward.
REQ-032 RESET SHALL override a simultaneous CPU_WR.
REQ-033 Pulses in progress SHALL terminate at the reset edge, and no stop pulse SHALL be generated by the reset.

Verification
REQ-034 Enable then trigger, defaults:
  - write addr 15 data 1;
  - write addr 3 data 1 at edge k;
  - required: O_SoundPort = 16'h0008 for exactly 16 cycles (edges k..k+15), then 0;
  - required: O_LATCH = 16'h8008.
REQ-035 Retrigger, defaults:
  - rewrite addr 3 with 0, then 1, 10 cycles into the pulse;
  - required: O_SoundPort[3] stays high continuously until 16 cycles after the second rising write;
  - required: O_SoundStop stays 0 (LOOP_MASK=0).
REQ-036 Loop stop, LOOP_MASK=16'h0002, PULSE_LEN=4:
  - set EN, set bit 1, then clear bit 1;
  - required: O_SoundPort[1] pulse ends at the clear edge;
  - required: O_SoundStop = 16'h0002 for 4 cycles.
REQ-037 Master disable, LOOP_MASK=16'h0006, PULSE_LEN=4:
  - latch bits 1 and 2 set;
  - clear bit 15;
  - required: O_SoundStop = 16'h0006 for 4 cycles;
  - then write bit 4 to 1: no O_SoundPort pulse, O_LATCH[4]=1.
REQ-038 Reset mid-pulse:
  - assert RESET with CPU_WR=1 during an active trigger pulse;
  - required: all outputs 0 after that edge;
  - required: no stop pulse after RESET deasserts.
